// File: rtl/snake_body_tracker_if.sv
// Tick/head/food/read-index bundle between the movement stage, display stage and body tracker.
// master drives the inputs of the tracker; slave is the tracker itself.
interface snake_body_tracker_if;
  logic        iIconTick;
  logic [10:0] iHeadX;
  logic [10:0] iHeadY;
  logic [10:0] iFoodX;
  logic [10:0] iFoodY;
  logic [6:0]  iRdIndex;
  logic [10:0] oRdX;
  logic [10:0] oRdY;
  logic        oRdValid;
  logic [7:0]  oSnakeLength;
  logic        oGameOver;
  logic        oFoodEaten;
  logic        oBusy;
  logic        oTickOverrun;

  modport master (
    output iIconTick, iHeadX, iHeadY, iFoodX, iFoodY, iRdIndex,
    input  oRdX, oRdY, oRdValid, oSnakeLength, oGameOver, oFoodEaten, oBusy, oTickOverrun
  );

  modport slave (
    input  iIconTick, iHeadX, iHeadY, iFoodX, iFoodY, iRdIndex,
    output oRdX, oRdY, oRdValid, oSnakeLength, oGameOver, oFoodEaten, oBusy, oTickOverrun
  );
endinterface

// File: rtl/snake_body_tracker.sv
// Snake body tracker: per-tick wall/food/self-collision checks against a circular head history.
// Tick-to-idle is 2+N cycles (N entries scanned); ticks arriving while busy are dropped and flagged.
module snake_body_tracker #(
  parameter int MAX_LEN  = 128,
  parameter int INIT_LEN = 20,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479
) (
  input logic                 Clock,
  input logic                 Reset,
  snake_body_tracker_if.slave bus
);
  localparam int          AW   = $clog2(MAX_LEN);
  localparam logic [7:0]  LMAX = 8'(MAX_LEN);
  localparam logic [11:0] XMIN = 12'(X_MIN);
  localparam logic [11:0] XMAX = 12'(X_MAX);
  localparam logic [11:0] YMIN = 12'(Y_MIN);
  localparam logic [11:0] YMAX = 12'(Y_MAX);

  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, COMMIT} state_t;
  state_t r_state, w_state_nxt;

  logic [10:0]   r_buf_x [MAX_LEN];
  logic [10:0]   r_buf_y [MAX_LEN];
  logic [AW-1:0] r_wp;
  logic [7:0]    r_filled, r_len, r_k, r_n;
  logic [10:0]   r_hx, r_hy;
  logic          r_hit_food, r_game_over, r_food_eaten, r_overrun;
  logic [10:0]   r_rd_x, r_rd_y;
  logic          r_rd_valid;

  logic          w_in_bounds, w_scan_hit, w_set_go, w_commit;
  logic [7:0]    w_len_m1, w_n, w_live;
  logic [AW-1:0] w_scan_ptr, w_rd_ptr;

  // Offset from the minimum wraps above the span when below it, so one compare covers both bounds.
  assign w_in_bounds = (({1'b0, bus.iHeadX} - XMIN) <= (XMAX - XMIN)) &&
                       (({1'b0, bus.iHeadY} - YMIN) <= (YMAX - YMIN));

  assign w_len_m1   = r_len - 8'd1;
  assign w_n        = (w_len_m1 < r_filled) ? w_len_m1 : r_filled;
  assign w_live     = (r_len < r_filled) ? r_len : r_filled;
  assign w_scan_ptr = r_wp - r_k[AW-1:0];
  assign w_scan_hit = (r_buf_x[w_scan_ptr] == r_hx) && (r_buf_y[w_scan_ptr] == r_hy);
  assign w_rd_ptr   = r_wp - AW'(1) - bus.iRdIndex[AW-1:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_set_go    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.iIconTick && !r_game_over) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!w_in_bounds) begin
          w_set_go    = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_n != 8'd0) begin
          w_state_nxt = SCAN;
        end else begin
          w_state_nxt = COMMIT;
        end
      end
      SCAN: begin
        if (w_scan_hit) begin
          w_set_go    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_k == r_n) begin
          w_state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wp         <= '0;
      r_filled     <= '0;
      r_len        <= 8'(INIT_LEN);
      r_k          <= '0;
      r_n          <= '0;
      r_hx         <= '0;
      r_hy         <= '0;
      r_hit_food   <= 1'b0;
      r_game_over  <= 1'b0;
      r_food_eaten <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_food_eaten <= w_commit && r_hit_food;
      if (w_set_go) r_game_over <= 1'b1;
      if (bus.iIconTick && (r_state != IDLE)) r_overrun <= 1'b1;
      if (r_state == CAPTURE) begin
        r_hx       <= bus.iHeadX;
        r_hy       <= bus.iHeadY;
        r_hit_food <= (bus.iHeadX == bus.iFoodX) && (bus.iHeadY == bus.iFoodY);
        r_n        <= w_n;
        r_k        <= 8'd1;
      end
      if (r_state == SCAN) r_k <= r_k + 8'd1;
      if (w_commit) begin
        r_wp <= r_wp + AW'(1);
        if (r_filled != LMAX) r_filled <= r_filled + 8'd1;
        if (r_hit_food && (r_len != LMAX)) r_len <= r_len + 8'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (w_commit) begin
      r_buf_x[r_wp] <= r_hx;
      r_buf_y[r_wp] <= r_hy;
    end
  end

  // Read index is relative to the current wp, so a read during COMMIT sees pre-write data.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rd_x     <= '0;
      r_rd_y     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_x     <= r_buf_x[w_rd_ptr];
      r_rd_y     <= r_buf_y[w_rd_ptr];
      r_rd_valid <= {1'b0, bus.iRdIndex} < w_live;
    end
  end

  assign bus.oRdX         = r_rd_x;
  assign bus.oRdY         = r_rd_y;
  assign bus.oRdValid     = r_rd_valid;
  assign bus.oSnakeLength = r_len;
  assign bus.oGameOver    = r_game_over;
  assign bus.oFoodEaten   = r_food_eaten;
  assign bus.oBusy        = (r_state != IDLE);
  assign bus.oTickOverrun = r_overrun;
endmodule
